// File: rtl/icache_direct_pkg.sv
// Shared OpenGPU definitions used by the instruction cache: bus widths,
// cache geometry defaults and the cache controller state type.
package pkg_opengpu;

  localparam int OG_ADDR_WIDTH     = 32;
  localparam int OG_INSTR_WIDTH    = 32;
  localparam int ICACHE_NUM_LINES  = 16;
  localparam int ICACHE_LINE_WORDS = 4;

  // state         | meaning
  // IC_IDLE       | waiting for a fetch; hit/miss decided here
  // IC_REFILL     | word request outstanding on the memory bus
  // IC_REFILL_GAP | one idle bus cycle between refill words
  // IC_RESP       | core_valid pulse; return to idle next cycle
  typedef enum logic [1:0] {
    IC_IDLE,
    IC_REFILL,
    IC_REFILL_GAP,
    IC_RESP
  } icache_state_t;

endpackage

// File: rtl/icache_direct_line_store.sv
// Tag/valid/data storage for the direct-mapped instruction cache.
// Combinational read by index, synchronous single-word write, bulk valid clear.
module icache_line_store #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 4,
  parameter int OFF_W      = 2,
  parameter int TAG_W      = 24,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_all_i,
  input  logic [IDX_W-1:0]  rd_index_i,
  input  logic [OFF_W-1:0]  rd_word_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_index_i,
  input  logic [OFF_W-1:0]  wr_word_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              fill_en_i,
  input  logic [TAG_W-1:0]  fill_tag_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [DATA_W-1:0]    data_q [NUM_LINES][LINE_WORDS];

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i][rd_word_i];

  // Valid bits: cleared by reset or flush, set when a line refill completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clear_all_i) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset; the valid bits qualify them
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[wr_index_i] <= fill_tag_i;
    end
    if (wr_en_i) begin
      data_q[wr_index_i][wr_word_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache between the core fetch port and
// the instruction memory bus. Define ICACHE_PERF_EN to add saturating
// hit/miss counters (perf_hits, perf_misses).
module icache_direct
  import pkg_opengpu::*;
#(
  parameter int ADDR_WIDTH  = OG_ADDR_WIDTH,
  parameter int INSTR_WIDTH = OG_INSTR_WIDTH,
  parameter int NUM_LINES   = ICACHE_NUM_LINES,
  parameter int LINE_WORDS  = ICACHE_LINE_WORDS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   core_req,
  input  logic [ADDR_WIDTH-1:0]  core_addr,
  output logic [INSTR_WIDTH-1:0] core_rdata,
  output logic                   core_valid,
  input  logic                   flush,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  input  logic                   mem_valid
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]            perf_hits,
  output logic [31:0]            perf_misses
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;

  icache_state_t    state_q;
  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] tag_q;
  logic [OFF_W-1:0] off_q;
  logic [OFF_W-1:0] cnt_q;
  logic             flush_pend_q;

  logic [OFF_W-1:0] off_in;
  logic [IDX_W-1:0] idx_in;
  logic [TAG_W-1:0] tag_in;
  logic             unused_addr_bits;

  logic [IDX_W-1:0]       rd_index;
  logic [OFF_W-1:0]       rd_word;
  logic                   rd_valid;
  logic [TAG_W-1:0]       rd_tag;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic                   wr_en;
  logic                   fill_en;
  logic                   clear_all;
  logic                   hit;

  assign off_in           = core_addr[2 +: OFF_W];
  assign idx_in           = core_addr[2 + OFF_W +: IDX_W];
  assign tag_in           = core_addr[ADDR_WIDTH-1 -: TAG_W];
  assign unused_addr_bits = ^core_addr[1:0];

  // In idle the store is looked up with the live address; afterwards the
  // latched index/offset govern so the core may change core_addr freely.
  assign rd_index = (state_q == IC_IDLE) ? idx_in : idx_q;
  assign rd_word  = (state_q == IC_IDLE) ? off_in : off_q;

  assign wr_en   = (state_q == IC_REFILL) && mem_valid;
  assign fill_en = wr_en && (cnt_q == OFF_W'(LINE_WORDS - 1));

  // A flush seen while busy is applied as the response retires, which also
  // drops the line that was just filled.
  assign clear_all = ((state_q == IC_IDLE) && flush) ||
                     ((state_q == IC_RESP) && (flush || flush_pend_q));

  assign hit = rd_valid && (rd_tag == tag_in) && !flush;

  icache_line_store #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W),
    .OFF_W      (OFF_W),
    .TAG_W      (TAG_W),
    .DATA_W     (INSTR_WIDTH)
  ) u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_all_i (clear_all),
    .rd_index_i  (rd_index),
    .rd_word_i   (rd_word),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .wr_en_i     (wr_en),
    .wr_index_i  (idx_q),
    .wr_word_i   (cnt_q),
    .wr_data_i   (mem_rdata),
    .fill_en_i   (fill_en),
    .fill_tag_i  (tag_q)
  );

  // Controller FSM with registered core and memory-side outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IC_IDLE;
      idx_q        <= '0;
      tag_q        <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      core_valid   <= 1'b0;
      core_rdata   <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
    end else begin
      unique case (state_q)
        IC_IDLE: begin
          if (core_req) begin
            if (hit) begin
              core_rdata <= rd_data;
              core_valid <= 1'b1;
              state_q    <= IC_RESP;
            end else begin
              idx_q    <= idx_in;
              tag_q    <= tag_in;
              off_q    <= off_in;
              cnt_q    <= '0;
              mem_req  <= 1'b1;
              mem_addr <= {tag_in, idx_in, {OFF_W{1'b0}}, 2'b00};
              state_q  <= IC_REFILL;
            end
          end
        end
        IC_REFILL: begin
          if (flush) flush_pend_q <= 1'b1;
          if (mem_valid) begin
            mem_req <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            state_q <= IC_REFILL_GAP;
          end
        end
        IC_REFILL_GAP: begin
          if (flush) flush_pend_q <= 1'b1;
          // The word counter wraps to zero only after the last word.
          if (cnt_q == '0) begin
            core_rdata <= rd_data;
            core_valid <= 1'b1;
            state_q    <= IC_RESP;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= {tag_q, idx_q, cnt_q, 2'b00};
            state_q  <= IC_REFILL;
          end
        end
        IC_RESP: begin
          core_valid   <= 1'b0;
          flush_pend_q <= 1'b0;
          state_q      <= IC_IDLE;
        end
        default: state_q <= IC_IDLE;
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  // Saturating hit/miss counters, one count per idle-state decision
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else if ((state_q == IC_IDLE) && core_req) begin
      if (hit && (perf_hits != '1)) perf_hits <= perf_hits + 1'b1;
      if (!hit && (perf_misses != '1)) perf_misses <= perf_misses + 1'b1;
    end
  end
`endif

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the compute core's fetch port and the shared instruction memory bus.
- Serves the core's level-held fetch request (imem_req/imem_addr → imem_rdata/imem_valid): 1-cycle response on hit, multi-word line refill on miss.
- Supports whole-cache invalidate (flush) for kernel reload.

Parameters:
- ADDR_WIDTH, 32, byte address width (from pkg_opengpu).
- INSTR_WIDTH, 32, instruction word width (from pkg_opengpu).
- NUM_LINES, 16, number of cache lines; power of two ≥ 2.
- LINE_WORDS, 4, words per line; power of two ≥ 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- core_req  in  1  fetch request, held high until core_valid is seen.
- core_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- core_rdata  out  INSTR_WIDTH  returned instruction.
- core_valid  out  1  one-cycle pulse: core_rdata is valid.
- flush  in  1  invalidate all lines.
- mem_req  out  1  backing-memory word request.
- mem_addr  out  ADDR_WIDTH  word-aligned refill address.
- mem_rdata  in  INSTR_WIDTH  backing-memory data.
- mem_valid  in  1  mem_rdata valid; one pulse per mem_req.

Behaviour:
- Address split: offset = addr[2 +: log2(LINE_WORDS)], index = next log2(NUM_LINES) bits, tag = remaining upper bits.
- Reset (synchronous, rst_n low at posedge):
  - state = IC_IDLE; all valid bits cleared.
  - core_valid = 0, core_rdata = 0; mem_req = 0, mem_addr = 0.
  - Pending flush and refill counter cleared.
  - Reset mid-refill aborts the refill; a late mem_valid after reset is ignored.
- IC_IDLE:
  - Request is sampled only here. The core's req stays high during IC_RESP and must not be treated as a second request.
  - core_req with valid line and tag match: latch data, go to IC_RESP.
  - core_req on a miss: latch index/tag/offset, counter = 0, go to IC_REFILL.
- IC_REFILL:
  - mem_req is registered. It is high with mem_addr = {tag, index, counter, 2'b00} until mem_valid.
  - On mem_valid: write the word into the line, counter++, and drop mem_req for exactly one cycle (IC_REFILL_GAP), then issue the next word.
  - After word LINE_WORDS-1: set valid and tag, latch the requested word (by saved offset), go to IC_RESP.
  - Words are always fetched 0..LINE_WORDS-1 (no critical-word-first).
- IC_RESP:
  - core_valid = 1 for exactly one cycle; next state IC_IDLE.
  - core_rdata holds its value until the next response.
- Hit latency: request in IC_IDLE at cycle N → core_valid at cycle N+1.
- Miss latency: 1 + LINE_WORDS × (mem latency + 1) + 1 cycles.
- Flush:
  - In IC_IDLE: clears all valid bits that cycle. A same-cycle core_req is treated as a miss.
  - In IC_REFILL/IC_RESP: latched as pending. The refill completes and the response is delivered. Pending flush is applied on entry to IC_IDLE and also invalidates the just-filled line.
- core_addr changes while not in IC_IDLE are ignored (latched address governs).
- Only one outstanding memory request at any time.

Optional Feature:
- Macro ICACHE_PERF_EN.
- Defined:
  - Adds outputs perf_hits and perf_misses (32-bit each), incremented on each IC_IDLE hit/miss decision.
  - Counters saturate at 0xFFFF_FFFF, reset to 0, and are unaffected by flush.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- pkg_opengpu adds:
  - icache_state_t {IC_IDLE, IC_REFILL, IC_REFILL_GAP, IC_RESP}.
  - ICACHE_NUM_LINES and ICACHE_LINE_WORDS defaults.
- One sub-module, icache_line_store:
  - Holds the tag/valid arrays and data arrays.
  - Combinational read by index; synchronous word write.
  - Bulk valid clear on flush/reset.

Test Plan:
- Cold miss: memory returns 0xA000_0000|addr with 2-cycle latency; fetch 0x100.
  - mem_addr sequence 0x100, 0x104, 0x108, 0x10C.
  - mem_req low one cycle between words.
  - core_valid pulses once with 0xA000_0100.
- Hit after fill: fetch 0x108 → core_valid the next cycle with 0xA000_0108; mem_req stays 0.
- Conflict: fetch 0x100, then 0x500 (same index 0), then 0x100 → three misses, each with a 4-word refill; final data 0xA000_0100.
- Flush: after 0x100 is filled, pulse flush in IC_IDLE, then fetch 0x104 → miss with a refill at 0x100.
  - Flush raised mid-refill → response still delivered, then a refetch of the same line misses.
- Reset mid-refill: rst_n low after word 1 → mem_req = 0 and core_valid = 0 next cycle; fetch 0x100 afterwards misses and refills from word 0.
- ICACHE_PERF_EN: sequence miss, hit, hit, miss → perf_hits = 2, perf_misses = 2.
